// File: rtl/if_id_queue.sv
// if_id_queue: the fetch-to-decode decoupling FIFO for the pipelined MIPS datapath.
// It holds {instruction, PC+4} pairs and presents the oldest one to decode,
// along with a beq predecode flag and the computed branch target.
// A flush discards every buffered entry on a taken branch or redirect.
module if_id_queue #(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc_plus4,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc_plus4,
  output logic             out_is_beq,
  output logic [31:0]      out_branch_target,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [5:0]     OP_BEQ     = 6'b000100;

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             push;
  logic             pop;
  logic             empty;
  logic [31:0]      head_instr;
  logic [31:0]      head_pc;
  logic [31:0]      branch_offset;

  // Handshake qualifiers. in_ready ignores out_ready, so no ready path runs
  // combinationally through the queue, and flush blocks both sides.
  always_comb begin
    empty     = (count == '0);
    in_ready  = (count != FULL_COUNT) & ~flush;
    out_valid = ~empty & ~flush;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Write side: store the entry at wr_ptr on each accepted push. Reset clears storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc_plus4;
    end
  end

  // Pointers and occupancy. Flush overrides everything. Pointers wrap naturally
  // because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head read and predecode. Data outputs are forced to zero while the queue is empty.
  always_comb begin
    head_instr = '0;
    head_pc    = '0;
    if (!empty) begin
      head_instr = instr_mem[rd_ptr];
      head_pc    = pc_mem[rd_ptr];
    end
    branch_offset     = {{14{head_instr[15]}}, head_instr[15:0], 2'b00};
    out_instr         = head_instr;
    out_pc_plus4      = head_pc;
    out_is_beq        = (head_instr[31:26] == OP_BEQ);
    out_branch_target = head_pc + branch_offset;
  end

endmodule
